// File: rtl/board_renderer.sv
// Pixel-colour stage behind the VGA timing generator: renders a 4x4 board of tile
// exponents from a per-frame shadow copy and re-times hsync/vsync to match the colour.
// Optional macro NEW_TILE_FLASH_EN adds cell_new and white flashing of new tiles.
module board_renderer #(
    parameter int unsigned BOARD_X0   = 128,
    parameter int unsigned BOARD_Y0   = 48,
    parameter int unsigned TILE_PITCH = 96,
    parameter int unsigned GAP        = 6
`ifdef NEW_TILE_FLASH_EN
    ,
    parameter int unsigned FLASH_FRAMES = 8
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       cell_we,
    input  logic [3:0] cell_addr,
    input  logic [3:0] cell_val,
`ifdef NEW_TILE_FLASH_EN
    input  logic       cell_new,
`endif
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned OFF_W  = 7;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned VAL_W  = 4;
    localparam int unsigned RGB_W  = 12;
    localparam int unsigned CELLS  = 16;
    localparam int unsigned BOARD_N = 4;
    localparam logic [RGB_W-1:0] BG_RGB = 12'h333;

    logic [POS_W-1:0] r_prev_hpos;
    logic             r_stb_d;
    logic             r_vs_prev;
    logic             w_stb;
    logic             w_vs_fall;

    logic [OFF_W-1:0] r_x_off, r_y_off, w_x_off_nxt, w_y_off_nxt;
    logic [IDX_W-1:0] r_col, r_row, w_col_nxt, w_row_nxt;
    logic             r_in_x, r_in_y, w_in_x_nxt, w_in_y_nxt;
    logic             r_de_s1, r_hs_s1, r_vs_s1;

    logic [VAL_W-1:0] r_live   [CELLS];
    logic [VAL_W-1:0] r_shadow [CELLS];
    logic [VAL_W-1:0] w_live_nxt [CELLS];
    logic [VAL_W-1:0] w_tile_val;
    logic             w_in_tile;

    logic [RGB_W-1:0] r_rgb, w_rgb;
    logic             r_hsync, r_vsync;

    assign w_stb     = (hpos != r_prev_hpos);
    assign w_vs_fall = r_vs_prev & ~vsync_in;

    function automatic logic [RGB_W-1:0] palette(input logic [VAL_W-1:0] v);
        logic [RGB_W-1:0] c;
        case (v)
            4'd0:                      c = 12'hCBA;
            4'd1:                      c = 12'hEED;
            4'd2:                      c = 12'hEDB;
            4'd3:                      c = 12'hFB7;
            4'd4:                      c = 12'hF96;
            4'd5:                      c = 12'hF75;
            4'd6:                      c = 12'hF53;
            4'd7, 4'd8, 4'd9, 4'd10:   c = {8'hEC, VAL_W'(v - 4'd3)};
            default:                   c = 12'h332;
        endcase
        return c;
    endfunction

    // Sample-every-clk registers: pixel strobe and vsync edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_hpos <= '0;
            r_stb_d     <= 1'b0;
            r_vs_prev   <= 1'b1;
        end else begin
            r_prev_hpos <= hpos;
            r_stb_d     <= w_stb;
            r_vs_prev   <= vsync_in;
        end
    end

    // Incremental tile position tracking; each axis restarts at the board edge.
    always_comb begin
        w_x_off_nxt = r_x_off + OFF_W'(1);
        w_col_nxt   = r_col;
        w_in_x_nxt  = r_in_x;
        if (hpos == POS_W'(BOARD_X0)) begin
            w_x_off_nxt = '0;
            w_col_nxt   = '0;
            w_in_x_nxt  = 1'b1;
        end else if (r_x_off == OFF_W'(TILE_PITCH - 1)) begin
            w_x_off_nxt = '0;
            w_col_nxt   = r_col + IDX_W'(1);
            if (r_col == IDX_W'(BOARD_N - 1)) w_in_x_nxt = 1'b0;
        end

        w_y_off_nxt = r_y_off + OFF_W'(1);
        w_row_nxt   = r_row;
        w_in_y_nxt  = r_in_y;
        if (vpos == POS_W'(BOARD_Y0)) begin
            w_y_off_nxt = '0;
            w_row_nxt   = '0;
            w_in_y_nxt  = 1'b1;
        end else if (r_y_off == OFF_W'(TILE_PITCH - 1)) begin
            w_y_off_nxt = '0;
            w_row_nxt   = r_row + IDX_W'(1);
            if (r_row == IDX_W'(BOARD_N - 1)) w_in_y_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_off <= '0;
            r_col   <= '0;
            r_in_x  <= 1'b0;
            r_y_off <= '0;
            r_row   <= '0;
            r_in_y  <= 1'b0;
            r_de_s1 <= 1'b0;
            r_hs_s1 <= 1'b1;
            r_vs_s1 <= 1'b1;
        end else if (w_stb) begin
            r_x_off <= w_x_off_nxt;
            r_col   <= w_col_nxt;
            r_in_x  <= w_in_x_nxt;
            if (hpos == '0) begin
                r_y_off <= w_y_off_nxt;
                r_row   <= w_row_nxt;
                r_in_y  <= w_in_y_nxt;
            end
            r_de_s1 <= display_on;
            r_hs_s1 <= hsync_in;
            r_vs_s1 <= vsync_in;
        end
    end

    // Live board takes writes; shadow snapshots it (including a same-clk write) at vsync fall.
    always_comb begin
        w_live_nxt = r_live;
        if (cell_we) w_live_nxt[cell_addr] = cell_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live   <= '{default: '0};
            r_shadow <= '{default: '0};
        end else begin
            r_live <= w_live_nxt;
            if (w_vs_fall) r_shadow <= w_live_nxt;
        end
    end

    assign w_tile_val = r_shadow[{r_row, r_col}];
    assign w_in_tile  = r_in_x && r_in_y && (r_x_off >= OFF_W'(GAP)) && (r_y_off >= OFF_W'(GAP));

`ifdef NEW_TILE_FLASH_EN
    localparam int unsigned CNT_W = 3;

    logic [CNT_W-1:0] r_flash_cnt [CELLS];
    logic [CNT_W-1:0] w_flash_cnt_nxt [CELLS];
    logic [CELLS-1:0] r_flash_sh, w_flash_sh_nxt;

    // Counters tick on vsync fall; a write (re)loads or clears its cell after the tick.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            w_flash_cnt_nxt[i] = r_flash_cnt[i];
            w_flash_sh_nxt[i]  = (r_flash_cnt[i] != '0);
            if (w_vs_fall && r_flash_cnt[i] != '0) w_flash_cnt_nxt[i] = r_flash_cnt[i] - CNT_W'(1);
        end
        if (cell_we) begin
            w_flash_cnt_nxt[cell_addr] = cell_new ? CNT_W'(FLASH_FRAMES - 1) : '0;
            w_flash_sh_nxt[cell_addr]  = cell_new;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flash_cnt <= '{default: '0};
            r_flash_sh  <= '0;
        end else begin
            r_flash_cnt <= w_flash_cnt_nxt;
            if (w_vs_fall) r_flash_sh <= w_flash_sh_nxt;
        end
    end

    always_comb begin
        w_rgb = '0;
        if (r_de_s1) begin
            if (!w_in_tile)                      w_rgb = BG_RGB;
            else if (r_flash_sh[{r_row, r_col}]) w_rgb = 12'hFFF;
            else                                 w_rgb = palette(w_tile_val);
        end
    end
`else
    always_comb begin
        w_rgb = '0;
        if (r_de_s1) begin
            if (!w_in_tile) w_rgb = BG_RGB;
            else            w_rgb = palette(w_tile_val);
        end
    end
`endif

    // Stage 2: colour and delayed syncs leave together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (r_stb_d) begin
            r_rgb   <= w_rgb;
            r_hsync <= r_hs_s1;
            r_vsync <= r_vs_s1;
        end
    end

    assign red   = r_rgb[11:8];
    assign green = r_rgb[7:4];
    assign blue  = r_rgb[3:0];
    assign hsync = r_hsync;
    assign vsync = r_vsync;

endmodule

// File: tb/tb_board_renderer.sv
// Randomized bench for board_renderer: compressed raster scans checked against a
// geometric pixel model of the board, palette and per-frame shadow copy.
module tb_board_renderer;

    localparam int X0 = 128;
    localparam int Y0 = 48;
    localparam int PITCH = 96;
    localparam int GAPW = 6;
    localparam int LAST_LINE = 440;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in;
    logic       cell_we;
    logic [3:0] cell_addr, cell_val;
`ifdef NEW_TILE_FLASH_EN
    logic       cell_new = 1'b0;
`endif
    logic [3:0] red, green, blue;
    logic       hsync, vsync;

    always #10 clk = ~clk;

    board_renderer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .cell_we    (cell_we),
        .cell_addr  (cell_addr),
        .cell_val   (cell_val),
`ifdef NEW_TILE_FLASH_EN
        .cell_new   (cell_new),
`endif
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0]  live_m   [16];
    logic [3:0]  shadow_m [16];
    logic [11:0] pal [16] = '{12'hCBA, 12'hEED, 12'hEDB, 12'hFB7, 12'hF96, 12'hF75, 12'hF53,
                              12'hEC4, 12'hEC5, 12'hEC6, 12'hEC7,
                              12'h332, 12'h332, 12'h332, 12'h332, 12'h332};
    logic [13:0] prev_exp;
    logic        last_vs_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected colour of pixel (x,y) from board geometry and the displayed board.
    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit de);
        if (!de) return 12'h000;
        if (x < X0 || x >= X0 + 4 * PITCH || y < Y0 || y >= Y0 + 4 * PITCH) return 12'h333;
        if ((x - X0) % PITCH < GAPW || (y - Y0) % PITCH < GAPW) return 12'h333;
        return pal[shadow_m[((y - Y0) / PITCH) * 4 + (x - X0) / PITCH]];
    endfunction

    function automatic logic [13:0] outs();
        return {red, green, blue, hsync, vsync};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            live_m[i]   = 4'h0;
            shadow_m[i] = 4'h0;
        end
        prev_exp   = {12'h000, 1'b1, 1'b1};
        last_vs_in = 1'b1;
    endtask

    task automatic idle_inputs();
        hpos = 10'd0; vpos = 10'd0; display_on = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        cell_we = 1'b0; cell_addr = 4'd0; cell_val = 4'd0;
    endtask

    // One pixel period (2 clk): outputs must hold the previous pixel for one clk, then switch.
    task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs,
                        input bit we, input int addr, input int val);
        logic [13:0] e;
        hpos = 10'(x); vpos = 10'(y); display_on = de; hsync_in = hs; vsync_in = vs;
        cell_we = we; cell_addr = 4'(addr); cell_val = 4'(val);
        if (we) live_m[addr] = 4'(val);
        if (last_vs_in && !vs) shadow_m = live_m;
        last_vs_in = vs;
        e = {exp_rgb(x, y, de), hs, vs};
        @(posedge clk); #1;
        cell_we = 1'b0;
        check($sformatf("hold x=%0d y=%0d", x, y), 32'(outs()), 32'(prev_exp));
        @(posedge clk); #1;
        check($sformatf("pix x=%0d y=%0d", x, y), 32'(outs()), 32'(e));
        prev_exp = e;
    endtask

    task automatic run_frame(input int s0, input int s1, input int s2, input int wr_pct,
                             input int dw_line, input int dw_addr, input int dw_val);
        for (int v = 0; v <= LAST_LINE; v++) begin
            if (v == s0 || v == s1 || v == s2) begin
                step(0, v, 1, 1, 1, 0, 0, 0);
                step(10, v, 1, 1, 1, 0, 0, 0);
                for (int x = X0; x <= X0 + 4 * PITCH + 8; x++) step(x, v, 1, 1, 1, 0, 0, 0);
                step(638, v, 1, 1, 1, 0, 0, 0);
                step(639, v, 0, 0, 1, 0, 0, 0);
                step(640, v, 0, 0, 1, 0, 0, 0);
                step(700, v, 0, 1, 1, 0, 0, 0);
            end else if (v == dw_line) begin
                step(0, v, 0, 1, 1, 1, dw_addr, dw_val);
                step(1, v, 0, 1, 1, 0, 0, 0);
            end else begin
                step(0, v, 0, 1, 1, ($urandom_range(99) < wr_pct),
                     $urandom_range(15), $urandom_range(15));
                step(1, v, 0, 1, 1, 0, 0, 0);
            end
        end
    endtask

    task automatic vsync_phase(input bit we, input int addr, input int val);
        step(0, 490, 0, 1, 1, 0, 0, 0);
        step(1, 490, 0, 1, 0, we, addr, val);
        step(0, 491, 0, 1, 0, 0, 0, 0);
        step(1, 491, 0, 1, 0, 0, 0, 0);
        step(0, 492, 0, 1, 1, 0, 0, 0);
        step(1, 492, 0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset outs", 32'(outs()), 32'({12'h000, 1'b1, 1'b1}));
        @(negedge clk);
        reset_n = 1'b1;

        // Empty board after reset: (200,100) empty tile, (10,10) background.
        run_frame(10, 60, 100, 0, -1, 0, 0);
        vsync_phase(0, 0, 0);

        // Mid-frame write to cell 5 must not show until the next frame.
        run_frame(150, 194, 300, 0, 50, 5, 3);
        vsync_phase(0, 0, 0);

        // Cell 5 now 3; write cell 0 on the vsync-fall clk.
        run_frame(60, 194, 420, 0, -1, 0, 0);
        vsync_phase(1, 0, 11);

        run_frame(60, 250, 431, 0, -1, 0, 0);
        vsync_phase(0, 0, 0);

        for (int f = 0; f < 3; f++) begin
            run_frame($urandom_range(LAST_LINE), $urandom_range(Y0, 431),
                      $urandom_range(Y0, 431), 30, -1, 0, 0);
            vsync_phase($urandom_range(1), $urandom_range(15), $urandom_range(15));
        end

        // Reset asserted mid-line while hsync is low and colour is non-zero.
        step(0, 300, 1, 1, 1, 0, 0, 0);
        step(5, 300, 1, 0, 1, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset outs", 32'(outs()), 32'({12'h000, 1'b1, 1'b1}));
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_frame(10, 100, 200, 0, -1, 0, 0);
        vsync_phase(0, 0, 0);

        run_frame($urandom_range(Y0, 431), 194, $urandom_range(LAST_LINE), 20, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
